// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a UART line and writes it into
// instruction memory, holding the downstream processor in reset until the
// whole image has been written.
//
// Image format: 16-bit big-endian word count N, then N 32-bit big-endian words.
//
// RX FSM   state    | meaning
//          RX_IDLE  | line idle, waiting for a falling edge
//          RX_START | waiting for the start-bit midpoint; high there = glitch
//          RX_DATA  | sampling 8 data bits, LSB first
//          RX_STOP  | sampling the stop bit; low = framing error
//
// Load FSM state    | meaning
//          HDR_HI   | waiting for word-count high byte
//          HDR_LO   | waiting for word-count low byte
//          DATA     | assembling and writing instruction words
//          DONE     | image complete, processor released (terminal)
//          ERR      | bad count or framing error (terminal)
module prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              w_imem_we,
  output logic [ADDR_W-1:0] w_imem_addr,
  output logic [31:0]       w_imem_wdata,
  output logic              w_proc_rst,
  output logic              w_busy,
  output logic              w_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam longint MAX_WORDS = longint'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} ld_state_t;

  logic              r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t         r_rx_state, w_rx_next;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_byte_valid, r_frame_err;

  ld_state_t         r_ld_state, w_ld_next;
  logic [7:0]        r_hdr_hi;
  logic [15:0]       r_remain;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_wr_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  logic              w_rx, w_rx_fall, w_cnt_zero, w_too_big;
  logic [15:0]       w_hdr_n;

  assign w_rx       = r_rx_s2;
  assign w_rx_fall  = r_rx_s3 & ~r_rx_s2;
  assign w_cnt_zero = (r_clk_cnt == '0);
  assign w_hdr_n    = {r_hdr_hi, r_shift};
  assign w_too_big  = ({48'd0, w_hdr_n} > MAX_WORDS);

  // Synchronize the async serial line; third flop only feeds edge detect.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= w_rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_rx_state <= RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  // RX next-state logic.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_cnt_zero) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_cnt_zero) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX bit timer (down-counter), shift register and byte/framing pulses.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: r_clk_cnt <= HALF_M1;
        RX_START: begin
          if (w_cnt_zero) begin
            r_clk_cnt <= FULL_M1;
            r_bit_idx <= '0;
          end else r_clk_cnt <= r_clk_cnt - CNT_W'(1);
        end
        RX_DATA: begin
          if (w_cnt_zero) begin
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            r_clk_cnt <= FULL_M1;
          end else r_clk_cnt <= r_clk_cnt - CNT_W'(1);
        end
        RX_STOP: begin
          if (w_cnt_zero) begin
            r_byte_valid <= w_rx;
            r_frame_err  <= ~w_rx;
          end else r_clk_cnt <= r_clk_cnt - CNT_W'(1);
        end
        default: r_clk_cnt <= HALF_M1;
      endcase
    end
  end

  // Load state register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_ld_state <= HDR_HI;
    else          r_ld_state <= w_ld_next;
  end

  // Load next-state logic; DONE is entered only after the last write cycle.
  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      HDR_HI: begin
        if (r_frame_err)       w_ld_next = ERR;
        else if (r_byte_valid) w_ld_next = HDR_LO;
      end
      HDR_LO: begin
        if (r_frame_err) w_ld_next = ERR;
        else if (r_byte_valid) begin
          if (w_too_big)             w_ld_next = ERR;
          else if (w_hdr_n == 16'd0) w_ld_next = DONE;
          else                       w_ld_next = DATA;
        end
      end
      DATA: begin
        if (r_frame_err)                        w_ld_next = ERR;
        else if (r_we && (r_remain == 16'd1))   w_ld_next = DONE;
      end
      DONE:    w_ld_next = DONE;
      ERR:     w_ld_next = ERR;
      default: w_ld_next = ERR;
    endcase
  end

  // Header capture, word assembly and the registered memory write port.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hdr_hi     <= '0;
      r_remain     <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_wr_idx     <= '0;
      r_we         <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_ld_state)
        HDR_HI: if (r_byte_valid) r_hdr_hi <= r_shift;
        HDR_LO: begin
          if (r_byte_valid) begin
            r_remain   <= w_hdr_n;
            r_byte_idx <= '0;
            r_wr_idx   <= '0;
          end
        end
        DATA: begin
          if (r_byte_valid) begin
            r_word     <= {r_word[23:0], r_shift};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_we         <= 1'b1;
              r_imem_wdata <= {r_word[23:0], r_shift};
              r_imem_addr  <= r_wr_idx;
              r_wr_idx     <= r_wr_idx + ADDR_W'(1);
            end
          end
          if (r_we) r_remain <= r_remain - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_imem_we    = r_we;
  assign w_imem_addr  = r_imem_addr;
  assign w_imem_wdata = r_imem_wdata;
  assign w_proc_rst   = (r_ld_state != DONE);
  assign w_busy       = (r_ld_state == DATA);
  assign w_err        = (r_ld_state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with 8 clocks per bit and a 16-word memory.
module tb_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          proc_rst, busy, err;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_rxd(rxd),
    .w_imem_we(imem_we), .w_imem_addr(imem_addr), .w_imem_wdata(imem_wdata),
    .w_proc_rst(proc_rst), .w_busy(busy), .w_err(err)
  );

  typedef struct {logic [AW-1:0] addr; logic [31:0] data; int cyc;} obs_t;
  typedef struct {logic [AW-1:0] addr; logic [31:0] data;} exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Observation side: records writes and timing facts; cleared while in reset.
  int            mon_cyc = 0;
  int            mon_run = 0, mon_max_run = 0, mon_hold_viol = 0;
  int            mon_rst_fall = -1, mon_busy_fall = -1;
  bit            mon_busy_seen = 1'b0;
  logic          mon_prev_proc = 1'b1, mon_prev_busy = 1'b0;
  logic [AW-1:0] mon_last_addr = '0;
  logic [31:0]   mon_last_data = '0;

  // Sample DUT outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon_cyc++;
    if (!rst_n) begin
      obs_q.delete();
      mon_run = 0; mon_max_run = 0; mon_hold_viol = 0;
      mon_rst_fall = -1; mon_busy_fall = -1; mon_busy_seen = 1'b0;
      mon_prev_proc = 1'b1; mon_prev_busy = 1'b0;
      mon_last_addr = '0; mon_last_data = '0;
    end else begin
      if (imem_we === 1'b1) begin
        mon_run++;
        obs_q.push_back('{imem_addr, imem_wdata, mon_cyc});
      end else begin
        mon_run = 0;
        if (imem_addr !== mon_last_addr || imem_wdata !== mon_last_data) mon_hold_viol++;
      end
      if (mon_run > mon_max_run) mon_max_run = mon_run;
      mon_last_addr = imem_addr;
      mon_last_data = imem_wdata;
      if (mon_prev_proc === 1'b1 && proc_rst === 1'b0) mon_rst_fall = mon_cyc;
      if (mon_prev_busy === 1'b1 && busy === 1'b0) mon_busy_fall = mon_cyc;
      if (busy === 1'b1) mon_busy_seen = 1'b1;
      mon_prev_proc = proc_rst;
      mon_prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0 ||
        proc_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: we=%b addr=%h data=%h prst=%b busy=%b err=%b, want 0 0 0 1 0 0",
               imem_we, imem_addr, imem_wdata, proc_rst, busy, err);
    end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || proc_rst !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: writes=%0d prst=%b busy=%b err=%b, want 0 1 0 0",
               obs_q.size(), proc_rst, busy, err);
    end
  endtask

  task automatic test_two_words;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || proc_rst !== 1'b1) begin
      failures++;
      $display("FAIL two_words_busy_after_hdr: busy=%b prst=%b, want 1 1", busy, proc_rst);
    end
    exp_q.push_back('{4'd0, 32'h24080005});
    send_word(32'h24080005);
    exp_q.push_back('{4'd1, 32'hAC080000});
    send_word(32'hAC080000);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL two_words_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q[i].addr !== e.addr || obs_q[i].data !== e.data) begin
        failures++;
        $display("FAIL two_words_write%0d: got addr=%h data=%h, want addr=%h data=%h",
                 i, obs_q[i].addr, obs_q[i].data, e.addr, e.data);
      end
    end
    checks++;
    if (mon_max_run != 1 || mon_hold_viol != 0) begin
      failures++;
      $display("FAIL two_words_strobe_hold: max_we_run=%0d hold_viol=%0d, want 1 0",
               mon_max_run, mon_hold_viol);
    end
    if (obs_q.size() == 2) begin
      checks++;
      if (mon_rst_fall != obs_q[1].cyc + 1 || mon_busy_fall != obs_q[1].cyc + 1) begin
        failures++;
        $display("FAIL two_words_release_timing: prst_fall=%0d busy_fall=%0d, want %0d",
                 mon_rst_fall, mon_busy_fall, obs_q[1].cyc + 1);
      end
    end
    checks++;
    if (proc_rst !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        imem_addr !== 4'd1 || imem_wdata !== 32'hAC080000) begin
      failures++;
      $display("FAIL two_words_final: prst=%b busy=%b err=%b addr=%h data=%h, want 0 0 0 1 ac080000",
               proc_rst, busy, err, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_wdata !== 32'h0 || imem_addr !== '0 || proc_rst !== 1'b1 || imem_we !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: data=%h addr=%h prst=%b we=%b, want 0 0 1 0",
               imem_wdata, imem_addr, proc_rst, imem_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_words;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (proc_rst !== 1'b0 || mon_busy_seen || obs_q.size() != 0) begin
      failures++;
      $display("FAIL zero_words: prst=%b busy_seen=%b writes=%0d, want 0 0 0",
               proc_rst, mon_busy_seen, obs_q.size());
    end
    send_byte(8'h12, 1'b0);
    send_word(32'h01020304);
    repeat (10) @(negedge clk);
    checks++;
    if (err !== 1'b0 || proc_rst !== 1'b0 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL done_ignores_input: err=%b prst=%b writes=%0d, want 0 0 0",
               err, proc_rst, obs_q.size());
    end
  endtask

  task automatic test_too_many;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1 || proc_rst !== 1'b1 || mon_busy_seen) begin
      failures++;
      $display("FAIL too_many_words: err=%b prst=%b busy_seen=%b, want 1 1 0",
               err, proc_rst, mon_busy_seen);
    end
    send_word(32'h55667788);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || err !== 1'b1 || proc_rst !== 1'b1) begin
      failures++;
      $display("FAIL too_many_terminal: writes=%0d err=%b prst=%b, want 0 1 1",
               obs_q.size(), err, proc_rst);
    end
  endtask

  task automatic test_max_words;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] w;
      w = $urandom;
      exp_q.push_back('{AW'(k), w});
      send_word(w);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 16 || err !== 1'b0 || proc_rst !== 1'b0) begin
      failures++;
      $display("FAIL max_words_count: writes=%0d err=%b prst=%b, want 16 0 0",
               obs_q.size(), err, proc_rst);
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q[i].addr !== e.addr || obs_q[i].data !== e.data) begin
        failures++;
        $display("FAIL max_words_write%0d: got addr=%h data=%h, want addr=%h data=%h",
                 i, obs_q[i].addr, obs_q[i].data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_glitch;
    reset_dut();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    exp_q.push_back('{4'd0, 32'h11223344});
    send_word(32'h11223344);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || err !== 1'b0 || proc_rst !== 1'b0) begin
      failures++;
      $display("FAIL glitch_no_byte: writes=%0d err=%b prst=%b, want 1 0 0",
               obs_q.size(), err, proc_rst);
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q[0].addr !== e.addr || obs_q[0].data !== e.data) begin
        failures++;
        $display("FAIL glitch_write: got addr=%h data=%h, want addr=%h data=%h",
                 obs_q[0].addr, obs_q[0].data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_frame_err;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1 || proc_rst !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_flag: err=%b prst=%b busy=%b, want 1 1 0", err, proc_rst, busy);
    end
    send_word(32'hCAFEF00D);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || err !== 1'b1 || proc_rst !== 1'b1) begin
      failures++;
      $display("FAIL frame_err_terminal: writes=%0d err=%b prst=%b, want 0 1 1",
               obs_q.size(), err, proc_rst);
    end
  endtask

  task automatic test_reset_mid_load;
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    checks++;
    if (busy !== 1'b1 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL mid_load_state: busy=%b writes=%0d, want 1 0", busy, obs_q.size());
    end
    reset_dut();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    exp_q.push_back('{4'd0, 32'hDEADBEEF});
    send_word(32'hDEADBEEF);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL mid_load_count: got %0d writes, want 1", obs_q.size());
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q[0].addr !== e.addr || obs_q[0].data !== e.data ||
          mon_rst_fall != obs_q[0].cyc + 1) begin
        failures++;
        $display("FAIL mid_load_write: got addr=%h data=%h prst_fall=%0d, want addr=%h data=%h prst_fall=%0d",
                 obs_q[0].addr, obs_q[0].data, mon_rst_fall, e.addr, e.data, obs_q[0].cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_async_reset();
    test_zero_words();
    test_too_many();
    test_max_words();
    test_glitch();
    test_frame_err();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
